// File: rtl/doraemon_result_tally_pkg.sv
// doraemon_result_tally_pkg: shared widths, in_data field positions and FSM encoding
package doraemon_result_tally_pkg;
   localparam int NUM_DOORS     = 5;
   localparam int DOOR_W        = 3;
   localparam int ID_W          = 5;
   localparam int CNT_W_DEFAULT = 13;
   localparam int DOOR_HI       = 7;
   localparam int DOOR_LO       = 5;
   localparam int ID_HI         = 4;
   localparam int ID_LO         = 0;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DUMP    = 2'd2,
      DONE    = 2'd3
   } state_t;
endpackage

// File: rtl/doraemon_result_tally_cell.sv
// door_tally_cell: saturating hit counter plus last-id register for one door
module door_tally_cell
   import doraemon_result_tally_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk2,
   input  logic             rst,
   input  logic             clear,
   input  logic             hit,
   input  logic [ID_W-1:0]  id,
   output logic [CNT_W-1:0] count,
   output logic [ID_W-1:0]  last_id
);
   logic [CNT_W-1:0] count_q, count_d;
   logic [ID_W-1:0]  last_id_q, last_id_d;
   always_comb begin
      count_d   = clear ? '0 : (hit && count_q != '1) ? count_q + 1'b1 : count_q;
      last_id_d = clear ? '0 : hit ? id : last_id_q;
   end
   always_ff @(posedge clk2) begin
      if (rst) begin
         count_q   <= '0;
         last_id_q <= '0;
      end else begin
         count_q   <= count_d;
         last_id_q <= last_id_d;
      end
   end
   assign count   = count_q;
   assign last_id = last_id_q;
endmodule

// File: rtl/doraemon_result_tally.sv
// doraemon_result_tally: tallies door selections per run, then dumps a 5-entry summary
module doraemon_result_tally
   import doraemon_result_tally_pkg::*;
#(
   parameter int TOTAL = 5996,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic              clk2,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [DOOR_W-1:0] dump_door,
   output logic [CNT_W-1:0]  dump_count,
   output logic [ID_W-1:0]   dump_last_id,
   output logic              done,
   output logic              busy,
   output logic              err_door,
   output logic              err_overflow
);
   localparam int TOT_W = $clog2(TOTAL + 1);
   localparam logic [TOT_W-1:0] LAST = TOT_W'(TOTAL - 1);
   state_t            state_q, state_d;
   logic [TOT_W-1:0]  total_q, total_d;
   logic [DOOR_W-1:0] idx_q, idx_d;
   logic              err_door_q, err_door_d, err_ovf_q, err_ovf_d;
   logic              accept, clear, take;
   logic [DOOR_W-1:0] door;
   logic [ID_W-1:0]   id;
   logic [CNT_W-1:0]  cnt [NUM_DOORS];
   logic [ID_W-1:0]   lid [NUM_DOORS];
   assign door   = in_data[DOOR_HI:DOOR_LO];
   assign id     = in_data[ID_HI:ID_LO];
   assign accept = in_valid && (state_q == IDLE || state_q == COLLECT);
   assign clear  = state_q == DONE;
   assign take   = dump_valid && dump_ready;
   for (genvar i = 0; i < NUM_DOORS; i++) begin : g_cell
      door_tally_cell #(.CNT_W(CNT_W)) u_cell (
         .clk2    (clk2),
         .rst     (rst),
         .clear   (clear),
         .hit     (accept && door == DOOR_W'(i)),
         .id      (id),
         .count   (cnt[i]),
         .last_id (lid[i])
      );
   end
   // Beats arriving outside IDLE/COLLECT are exactly the dropped ones.
   always_comb begin
      total_d    = clear ? '0 : total_q + TOT_W'(accept);
      idx_d      = clear ? '0 : idx_q + DOOR_W'(take);
      err_door_d = err_door_q | (accept && door >= DOOR_W'(NUM_DOORS));
      err_ovf_d  = err_ovf_q | (in_valid && !accept);
      state_d    = accept ? (total_q == LAST ? DUMP : COLLECT)
                 : (take && idx_q == DOOR_W'(NUM_DOORS - 1)) ? DONE
                 : clear ? IDLE : state_q;
   end
   always_ff @(posedge clk2) begin
      if (rst) begin
         state_q    <= IDLE;
         total_q    <= '0;
         idx_q      <= '0;
         err_door_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         idx_q      <= idx_d;
         err_door_q <= err_door_d;
         err_ovf_q  <= err_ovf_d;
      end
   end
   assign dump_valid   = state_q == DUMP;
   assign dump_door    = dump_valid ? idx_q : '0;
   assign dump_count   = dump_valid ? cnt[idx_q] : '0;
   assign dump_last_id = dump_valid ? lid[idx_q] : '0;
   assign done         = state_q == DONE;
   assign busy         = state_q == COLLECT || state_q == DUMP;
   assign err_door     = err_door_q;
   assign err_overflow = err_ovf_q;
endmodule

// File: tb/tb_doraemon_result_tally.sv
// tb_doraemon_result_tally: scoreboard bench for the result tally and its saturating variant
module tb_doraemon_result_tally;
   typedef struct {
      logic [2:0]  door;
      logic [31:0] count;
      logic [4:0]  last;
   } entry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst = 1'b1, a_in_valid = 1'b0, a_ready = 1'b0;
   logic [7:0]  a_in_data = '0;
   logic        a_valid, a_done, a_busy, a_err_door, a_err_ovf;
   logic [2:0]  a_door;
   logic [12:0] a_count;
   logic [4:0]  a_last;

   logic        b_rst = 1'b1, b_in_valid = 1'b0, b_ready = 1'b0;
   logic [7:0]  b_in_data = '0;
   logic        b_valid, b_done, b_busy, b_err_door, b_err_ovf;
   logic [2:0]  b_door;
   logic [2:0]  b_count;
   logic [4:0]  b_last;

   doraemon_result_tally #(.TOTAL(10), .CNT_W(13)) u_dut (
      .clk2(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
      .dump_ready(a_ready), .dump_valid(a_valid), .dump_door(a_door),
      .dump_count(a_count), .dump_last_id(a_last), .done(a_done), .busy(a_busy),
      .err_door(a_err_door), .err_overflow(a_err_ovf)
   );

   doraemon_result_tally #(.TOTAL(9), .CNT_W(3)) u_sat (
      .clk2(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
      .dump_ready(b_ready), .dump_valid(b_valid), .dump_door(b_door),
      .dump_count(b_count), .dump_last_id(b_last), .done(b_done), .busy(b_busy),
      .err_door(b_err_door), .err_overflow(b_err_ovf)
   );

   int checks = 0;
   int passes = 0;
   entry_t qa[$];
   entry_t qb[$];
   bit done_exp_a = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_a(input int d, input int c, input int l);
      entry_t e;
      e.door = 3'(d); e.count = 32'(c); e.last = 5'(l);
      qa.push_back(e);
   endtask

   task automatic push_b(input int d, input int c, input int l);
      entry_t e;
      e.door = 3'(d); e.count = 32'(c); e.last = 5'(l);
      qb.push_back(e);
   endtask

   always @(negedge clk) begin
      entry_t e;
      if (done_exp_a) chk("done_pulse", 32'(a_done), 1);
      else if (a_done) chk("done_spurious", 32'(a_done), 0);
      done_exp_a = 0;
      if (a_valid && a_ready) begin
         if (qa.size() == 0) chk("a_unexpected_entry", 32'(a_door), 32'hffff_ffff);
         else begin
            e = qa.pop_front();
            chk("a_door", 32'(a_door), 32'(e.door));
            chk("a_count", 32'(a_count), e.count);
            chk("a_last_id", 32'(a_last), 32'(e.last));
            done_exp_a = (e.door == 3'd4);
         end
      end
   end

   always @(negedge clk) begin
      entry_t e;
      if (b_valid && b_ready) begin
         if (qb.size() == 0) chk("b_unexpected_entry", 32'(b_door), 32'hffff_ffff);
         else begin
            e = qb.pop_front();
            chk("b_door", 32'(b_door), 32'(e.door));
            chk("b_count", 32'(b_count), e.count);
            chk("b_last_id", 32'(b_last), 32'(e.last));
         end
      end
   end

   task automatic send_a(input int door, input int id);
      a_in_valid = 1'b1;
      a_in_data  = {3'(door), 5'(id)};
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic dump_a(input int hold_at, input bit ovf);
      int held = 0;
      bit got = 0;
      logic [2:0]  hd;
      logic [12:0] hc;
      logic [4:0]  hl;
      a_ready = 1'b1;
      if (ovf) begin
         a_in_valid = 1'b1;
         a_in_data  = 8'h00;
      end
      for (int c = 0; c < 60; c++) begin
         if (a_done) begin
            got = 1;
            break;
         end
         if (a_valid && a_door == 3'(hold_at) && held < 3) begin
            if (held == 0) begin
               hd = a_door; hc = a_count; hl = a_last;
            end else begin
               chk("hold_valid", 32'(a_valid), 1);
               chk("hold_door", 32'(a_door), 32'(hd));
               chk("hold_count", 32'(a_count), 32'(hc));
               chk("hold_last_id", 32'(a_last), 32'(hl));
            end
            a_ready = 1'b0;
            held++;
         end else a_ready = 1'b1;
         @(posedge clk); #1;
         a_in_valid = 1'b0;
      end
      if (!got) chk("a_dump_timeout", 0, 1);
      a_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_valid"}, 32'(a_valid), 0);
      chk({tag, "_door"}, 32'(a_door), 0);
      chk({tag, "_count"}, 32'(a_count), 0);
      chk({tag, "_last_id"}, 32'(a_last), 0);
      chk({tag, "_done"}, 32'(a_done), 0);
      chk({tag, "_busy"}, 32'(a_busy), 0);
      chk({tag, "_err_door"}, 32'(a_err_door), 0);
      chk({tag, "_err_ovf"}, 32'(a_err_ovf), 0);
   endtask

   initial begin
      bit got;
      repeat (2) @(posedge clk);
      #1;
      chk_zero_a("reset");
      a_rst = 1'b0;
      b_rst = 1'b0;
      @(posedge clk); #1;

      // Run 1: round-robin doors with ids 1..10, hold at entry 2, overflow beat in DUMP
      for (int i = 0; i < 10; i++) begin
         send_a(i % 5, i + 1);
         if (i == 0) chk("busy_collect", 32'(a_busy), 1);
         if (i == 8) chk("no_early_dump", 32'(a_valid), 0);
      end
      chk("dv_latency", 32'(a_valid), 1);
      chk("busy_dump", 32'(a_busy), 1);
      for (int d = 0; d < 5; d++) push_a(d, 2, d + 6);
      dump_a(2, 1);
      chk("err_ovf_set", 32'(a_err_ovf), 1);
      chk("err_door_clear", 32'(a_err_door), 0);
      chk("idle_busy", 32'(a_busy), 0);

      // Run 2: fresh tallies after done, sticky overflow persists
      send_a(4, 5); send_a(4, 6);
      send_a(3, 7); send_a(3, 8); send_a(3, 9);
      send_a(2, 10);
      send_a(1, 11); send_a(1, 12); send_a(1, 13); send_a(1, 14);
      push_a(0, 0, 0); push_a(1, 4, 14); push_a(2, 1, 10); push_a(3, 3, 9); push_a(4, 2, 6);
      dump_a(-1, 0);
      chk("err_ovf_sticky", 32'(a_err_ovf), 1);

      // Mid-collect reset after 3 beats
      send_a(0, 1); send_a(1, 2); send_a(2, 3);
      a_rst = 1'b1;
      @(posedge clk); #1;
      a_rst = 1'b0;
      chk_zero_a("midrst");

      // Run 3: bad door first, then nine door-0 beats
      send_a(5, 3);
      for (int i = 1; i <= 9; i++) send_a(0, i);
      chk("err_door_set", 32'(a_err_door), 1);
      push_a(0, 9, 9);
      for (int d = 1; d < 5; d++) push_a(d, 0, 0);
      dump_a(-1, 0);
      chk("a_queue_drained", 32'(qa.size()), 0);

      // Saturating variant: 9 beats on door 1 with a 3-bit counter
      for (int i = 1; i <= 9; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = {3'd1, 5'(i)};
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      chk("b_dv_latency", 32'(b_valid), 1);
      push_b(0, 0, 0); push_b(1, 7, 9); push_b(2, 0, 0); push_b(3, 0, 0); push_b(4, 0, 0);
      b_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40; c++) begin
         if (b_done) begin
            got = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!got) chk("b_dump_timeout", 0, 1);
      b_ready = 1'b0;
      chk("b_err_door", 32'(b_err_door), 0);
      @(posedge clk); #1;
      chk("b_queue_drained", 32'(qb.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
